// File: rtl/ct_reader_if.sv
// Bus between the AES core / host and the ciphertext reader.
// The reader takes the slave modport; the bench or host logic takes master.
interface ct_reader_if #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 8
);
  logic [WORD_W*WORDS-1:0] ct;
  logic                    ct_valid;
  logic                    rd_clk;
  logic [WORD_W-1:0]       out;
  logic                    out_valid;
  logic                    done;
  logic                    overrun;
  logic                    underrun;

  modport slave (
    input  ct, ct_valid, rd_clk,
    output out, out_valid, done, overrun, underrun
  );

  modport master (
    output ct, ct_valid, rd_clk,
    input  out, out_valid, done, overrun, underrun
  );
endinterface

// File: rtl/ct_reader.sv
// Holds one 128-bit ciphertext block and hands it to a slow host one word per
// rising edge of the host's asynchronous read strobe, most-significant word first.
module ct_reader #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 8
) (
  input  logic         clk,
  input  logic         rst,
  ct_reader_if.slave   bus
);

  localparam int BLK_W = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOADED = 1'b1;

  if (BLK_W != 128) begin : gParamCheck
    $error("ct_reader: WORD_W*WORDS must equal 128");
  end

  logic             s0_q, s1_q, s2_q;
  logic [2:0]       warm_q;
  logic             rdEdge;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic             outValid_q, outValid_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;

  logic [BLK_W-1:0] blkShift;
  logic [WORD_W-1:0] loadWord;

  // warm_q marks when s2 holds a genuine sample, so a strobe already high at
  // reset release never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      warm_q <= '0;
    end else begin
      s0_q   <= bus.rd_clk;
      s1_q   <= s0_q;
      s2_q   <= s1_q;
      warm_q <= {warm_q[1:0], 1'b1};
    end
  end

  assign rdEdge   = s1_q & ~s2_q & warm_q[2];
  assign blkShift = blk_q << WORD_W;
  assign loadWord = bus.ct[BLK_W-1 -: WORD_W];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    blk_d      = blk_q;
    out_d      = out_q;
    outValid_d = outValid_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    case (state_q)
      IDLE: begin
        if (rdEdge) underrun_d = 1'b1;
        if (bus.ct_valid) begin
          state_d    = LOADED;
          idx_d      = '0;
          blk_d      = bus.ct;
          out_d      = loadWord;
          outValid_d = 1'b1;
        end
      end
      default: begin
        if (rdEdge && idx_q == LAST_IDX) begin
          done_d = 1'b1;
          // A block arriving exactly as the last word goes is accepted, not an overrun.
          if (bus.ct_valid) begin
            idx_d      = '0;
            blk_d      = bus.ct;
            out_d      = loadWord;
            outValid_d = 1'b1;
          end else begin
            state_d    = IDLE;
            idx_d      = '0;
            blk_d      = '0;
            out_d      = '0;
            outValid_d = 1'b0;
          end
        end else begin
          if (rdEdge) begin
            idx_d = idx_q + IDX_W'(1);
            blk_d = blkShift;
            out_d = blkShift[BLK_W-1 -: WORD_W];
          end
          if (bus.ct_valid) overrun_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      blk_q      <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      blk_q      <= blk_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = outValid_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_ct_reader.sv
// Directed bench for ct_reader: a vector table for the main read flows plus
// hand-timed sequences for coincident load/last-read, reset mid-read and strobe phase sweep.
module tb_ct_reader;

  typedef enum int {OP_NONE, OP_LOAD, OP_READ, OP_RESET} op_e;

  typedef struct {
    op_e          op;
    logic [127:0] data;
    logic [15:0]  expOut;
    logic         expValid;
    logic         expOver;
    logic         expUnder;
    int           expDone;
  } vec_t;

  localparam logic [127:0] BLK_A = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] BLK_B = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

  logic clk;
  logic rst;
  int   vecCnt;
  int   misCnt;
  int   doneCnt;
  int   doneMark;
  vec_t vecs[$];
  logic [15:0] aWords [8];
  logic [15:0] bWords [8];

  ct_reader_if #(.WORD_W(16), .WORDS(8)) bus ();

  ct_reader #(.WORD_W(16), .WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) doneCnt = doneCnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(op_e op, logic [127:0] d, logic [15:0] o,
                                 logic v, logic ov, logic un, int dn);
    vec_t r;
    r.op = op; r.data = d; r.expOut = o;
    r.expValid = v; r.expOver = ov; r.expUnder = un; r.expDone = dn;
    vecs.push_back(r);
  endfunction

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCnt = vecCnt + 1;
    if (act !== exp) begin
      misCnt = misCnt + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] eo, input logic ev,
                             input logic eov, input logic eun, input int edn);
    #1;
    compare({tag, " out"}, 128'(bus.out), 128'(eo));
    compare({tag, " out_valid"}, 128'(bus.out_valid), 128'(ev));
    compare({tag, " overrun"}, 128'(bus.overrun), 128'(eov));
    compare({tag, " underrun"}, 128'(bus.underrun), 128'(eun));
    compare({tag, " done pulses"}, 128'(doneCnt - doneMark), 128'(edn));
    doneMark = doneCnt;
  endtask

  task automatic loadBlock(input logic [127:0] d);
    @(negedge clk);
    bus.ct       = d;
    bus.ct_valid = 1'b1;
    @(negedge clk);
    bus.ct_valid = 1'b0;
    bus.ct       = '0;
  endtask

  task automatic readStrobe(input int phase, input int highNs, input int lowNs);
    @(negedge clk);
    #phase bus.rd_clk = 1'b1;
    #highNs bus.rd_clk = 1'b0;
    #lowNs;
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    doneMark = doneCnt;
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.op)
      OP_LOAD:  loadBlock(v.data);
      OP_READ:  readStrobe(2, 30, 30);
      OP_RESET: doReset();
      default:  @(negedge clk);
    endcase
  endtask

  initial begin
    vecCnt = 0; misCnt = 0; doneCnt = 0; doneMark = 0;
    aWords = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};
    bWords = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
    bus.ct = '0; bus.ct_valid = 1'b0; bus.rd_clk = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Full read of A, strobe into an empty reader, full read of B.
    addVec(OP_NONE, '0, 16'h0000, 0, 0, 0, 0);
    addVec(OP_LOAD, BLK_A, 16'h0011, 1, 0, 0, 0);
    for (int i = 1; i < 8; i++) addVec(OP_READ, '0, aWords[i], 1, 0, 0, 0);
    addVec(OP_READ, '0, 16'h0000, 0, 0, 0, 1);
    addVec(OP_READ, '0, 16'h0000, 0, 0, 1, 0);
    addVec(OP_LOAD, BLK_B, 16'hFEDC, 1, 0, 1, 0);
    for (int i = 1; i < 8; i++) addVec(OP_READ, '0, bWords[i], 1, 0, 1, 0);
    addVec(OP_READ, '0, 16'h0000, 0, 0, 1, 1);
    // Overrun: B arrives after three words of A have been consumed.
    addVec(OP_RESET, '0, 16'h0000, 0, 0, 0, 0);
    addVec(OP_LOAD, BLK_A, 16'h0011, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++) addVec(OP_READ, '0, aWords[i], 1, 0, 0, 0);
    addVec(OP_LOAD, BLK_B, 16'h6677, 1, 1, 0, 0);
    for (int i = 4; i < 8; i++) addVec(OP_READ, '0, aWords[i], 1, 1, 0, 0);
    addVec(OP_READ, '0, 16'h0000, 0, 1, 0, 1);

    repeat (3) @(negedge clk);
    checkOutput("in reset", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expValid,
                  vecs[i].expOver, vecs[i].expUnder, vecs[i].expDone);
    end

    // Load of B lands on the same edge that consumes A's last word.
    doReset();
    loadBlock(BLK_A);
    for (int i = 1; i < 8; i++) readStrobe(2, 30, 30);
    checkOutput("coinc pre", 16'hEEFF, 1, 0, 0, 0);
    @(negedge clk);
    bus.rd_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.ct = BLK_B;
    bus.ct_valid = 1'b1;
    @(negedge clk);
    bus.ct_valid = 1'b0;
    bus.ct = '0;
    #1;
    compare("coinc done now", 128'(bus.done), 128'(1'b1));
    compare("coinc out now", 128'(bus.out), 128'(16'hFEDC));
    bus.rd_clk = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("coinc load", 16'hFEDC, 1, 0, 0, 1);
    for (int i = 1; i < 8; i++) begin
      readStrobe(2, 30, 30);
      checkOutput($sformatf("coinc B%0d", i), bWords[i], 1, 0, 0, 0);
    end
    readStrobe(2, 30, 30);
    checkOutput("coinc end", 16'h0000, 0, 0, 0, 1);

    // Reset mid-read while the strobe is high and stays high through release.
    doReset();
    loadBlock(BLK_A);
    for (int i = 1; i < 5; i++) readStrobe(2, 30, 30);
    checkOutput("rstmid pre", 16'h8899, 1, 0, 0, 0);
    @(negedge clk);
    bus.rd_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmid held", 16'h0000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rstmid release", 16'h0000, 0, 0, 0, 0);
    bus.rd_clk = 1'b0;
    repeat (3) @(negedge clk);
    readStrobe(2, 30, 30);
    checkOutput("rstmid strobe", 16'h0000, 0, 0, 1, 0);
    loadBlock(BLK_A);
    checkOutput("rstmid reload", 16'h0011, 1, 0, 1, 0);

    // Minimum-width strobes at assorted phases against clk.
    doReset();
    loadBlock(BLK_A);
    begin
      int phases [8];
      phases = '{1, 4, 3, 6, 7, 8, 9, 2};
      for (int i = 0; i < 8; i++) begin
        readStrobe(phases[i], 20 + (i % 2) * 2, 20);
        if (i < 7)
          checkOutput($sformatf("sweep%0d", i), aWords[i+1], 1, 0, 0, 0);
        else
          checkOutput("sweep last", 16'h0000, 0, 0, 0, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, misCnt);
    $finish;
  end

endmodule
